// File: rtl/imm_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imm_decode_stage                                           |
// | Description : Registered, valid/ready immediate-decode stage. Extracts   |
// |               and extends the RV32I/RV64I immediate, classifies the      |
// |               format, computes pc+imm and flags unknown opcodes. A       |
// |               2-entry skid buffer gives full throughput without a        |
// |               combinational ready path.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module imm_decode_stage #(
    parameter int XLEN     = 64,
    parameter bit CSR_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    localparam logic [2:0] C_FMT_NONE    = 3'd0;
    localparam logic [2:0] C_FMT_I       = 3'd1;
    localparam logic [2:0] C_FMT_S       = 3'd2;
    localparam logic [2:0] C_FMT_B       = 3'd3;
    localparam logic [2:0] C_FMT_U       = 3'd4;
    localparam logic [2:0] C_FMT_J       = 3'd5;
    localparam logic [2:0] C_FMT_Z       = 3'd6;
    localparam logic [2:0] C_FMT_ILLEGAL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    logic [31:0]     w_imm32;
    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;
    entry_t          w_new;
    logic            w_accept;

    entry_t m_q, m_d, s_q, s_d;
    logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;

    // Decode the incoming word into a 32-bit immediate (zimm has bit 31 clear,
    // so one sign extension below serves every format).
    always_comb begin
        w_imm32 = 32'd0;
        w_fmt   = C_FMT_ILLEGAL;
        unique case (in_instr[6:0])
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                w_fmt   = C_FMT_I;
            end
            7'b0100011: begin
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                w_fmt   = C_FMT_S;
            end
            7'b1100011: begin
                w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
                w_fmt   = C_FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                w_imm32 = {in_instr[31:12], 12'd0};
                w_fmt   = C_FMT_U;
            end
            7'b1101111: begin
                w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
                w_fmt   = C_FMT_J;
            end
            7'b1110011: begin
                if (CSR_ZIMM) begin
                    w_imm32 = {27'd0, in_instr[19:15]};
                    w_fmt   = C_FMT_Z;
                end else begin
                    w_fmt   = C_FMT_NONE;
                end
            end
            7'b0110011, 7'b0111011, 7'b0001111: begin
                w_fmt   = C_FMT_NONE;
            end
            default: begin
                w_imm32 = 32'd0;
                w_fmt   = C_FMT_ILLEGAL;
            end
        endcase
    end

    if (XLEN > 32) begin : g_xlen_wide
        assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_xlen_32
        assign w_imm = w_imm32;
    end

    assign w_new.imm    = w_imm;
    assign w_new.fmt    = w_fmt;
    assign w_new.target = in_pc + w_imm;
    assign w_new.pc     = in_pc;
    assign w_new.instr  = in_instr;

    // Ready depends only on skid occupancy, never on out_ready.
    assign in_ready = !s_valid_q && !rst;
    assign w_accept = in_valid && in_ready;

    // Next-state of main/skid entries: M refills from S first, else from input.
    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || out_ready) begin
            if (s_valid_q) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end else if (w_accept) begin
                m_d       = w_new;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            s_d       = w_new;
            s_valid_d = 1'b1;
        end
    end

    // State registers; reset clears payloads so the outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign out_valid  = m_valid_q;
    assign out_imm    = m_q.imm;
    assign out_fmt    = m_q.fmt;
    assign out_target = m_q.target;
    assign out_pc     = m_q.pc;
    assign out_instr  = m_q.instr;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_imm_decode_stage                                        |
// | Description : Directed self-checking bench for imm_decode_stage (XLEN=64 |
// |               main instance, XLEN=32/CSR_ZIMM=0 side instance).          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [63:0] in_pc = 64'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [63:0] out_imm, out_target, out_pc;
    logic [2:0]  out_fmt;
    logic [31:0] out_instr;

    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32, out_target32, out_pc32, out_instr32;
    logic [2:0]  out_fmt32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(64), .CSR_ZIMM(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    imm_decode_stage #(.XLEN(32), .CSR_ZIMM(1'b0)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_target(out_target32),
        .out_pc(out_pc32), .out_instr(out_instr32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction with out_ready=1 and check the registered result.
    task automatic send_check(input string tag, input logic [31:0] instr,
                              input logic [63:0] pc, input logic [63:0] eimm,
                              input logic [2:0] efmt, input logic [63:0] etgt);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_valid"},  {63'd0, out_valid}, 64'd1);
        chk({tag, "_imm"},    out_imm, eimm);
        chk({tag, "_fmt"},    {61'd0, out_fmt}, {61'd0, efmt});
        chk({tag, "_target"}, out_target, etgt);
        chk({tag, "_pc"},     out_pc, pc);
        chk({tag, "_instr"},  {32'd0, out_instr}, {32'd0, instr});
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          sent, recvd, cyc;
    logic        in_fire, out_fire;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_imm",   out_imm, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed decodes
        send_check("addi", 32'hFFF0_0093, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'hFF);
        send_check("lui",  32'h8000_00B7, 64'h0,   64'hFFFF_FFFF_8000_0000, 3'd4, 64'hFFFF_FFFF_8000_0000);
        chk("lui_x32_imm", {32'd0, out_imm32}, 64'h8000_0000);
        send_check("beq",  32'hFE00_0EE3, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 64'hFFC);
        send_check("sw",   32'hFE00_0FA3, 64'h20,  64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 64'h1F);
        send_check("jal",  32'h0010_006F, 64'h0,   64'h800, 3'd5, 64'h800);
        send_check("csr",  32'h000F_D073, 64'h40,  64'h1F, 3'd6, 64'h5F);
        chk("csr_x32_fmt", {61'd0, out_fmt32}, 64'd0);
        chk("csr_x32_imm", {32'd0, out_imm32}, 64'd0);
        send_check("ill",  32'h0000_007F, 64'h80,  64'h0, 3'd7, 64'h80);
        send_check("add",  32'h0020_80B3, 64'h84,  64'h0, 3'd0, 64'h84);
        tick();
        chk("drained", {63'd0, out_valid}, 64'd0);

        // Random-backpressure stream of 8 ADDIs, imm = 3*k+1
        sent = 0; recvd = 0; cyc = 0;
        while (recvd < 8 && cyc < 200) begin
            in_valid  = (sent < 8);
            in_instr  = {12'(3*sent+1), 5'd0, 3'd0, 5'd1, 7'b0010011};
            in_pc     = 64'(sent * 4);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                e = exp_q.pop_front();
                chk("stream_instr", {32'd0, out_instr}, {32'd0, e});
                chk("stream_imm", out_imm, {52'd0, e[31:20]});
                recvd++;
            end
            if (in_fire) begin
                exp_q.push_back(in_instr);
                sent++;
            end
            tick();
            cyc++;
        end
        chk("stream_count", 64'(recvd), 64'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Full throughput: out_ready held high, one transfer every cycle
        recvd = 0;
        for (int k = 0; k < 9; k++) begin
            in_valid = (k < 8);
            in_instr = {12'(k), 5'd0, 3'd0, 5'd2, 7'b0010011};
            @(negedge clk);
            if (k < 8 && !in_ready) chk("tput_in_ready", 64'd0, 64'd1);
            if (k > 0) begin
                chk("tput_out_valid", {63'd0, out_valid}, 64'd1);
                chk("tput_imm", out_imm, 64'(k - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Stall fill, then flush
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 64'h200;
        tick();
        chk("fill_a_ready", {63'd0, in_ready}, 64'd1);
        in_instr = 32'h0020_0093; in_pc = 64'h204;
        tick();
        chk("fill_b_ready", {63'd0, in_ready}, 64'd0);
        chk("fill_head_imm", out_imm, 64'd1);
        flush = 1'b1; in_instr = 32'h0030_0093;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready",  {63'd0, in_ready}, 64'd1);

        // Flush overriding a same-cycle accept (in_ready high)
        in_valid = 1'b1; in_instr = 32'h0040_0093;
        tick();
        flush = 1'b1; in_instr = 32'h0050_0093;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush2_out_valid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("flush2_discard", {63'd0, out_valid}, 64'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 64'h300;
        tick();
        in_instr = 32'h8000_00B7;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mrst_out_valid",  {63'd0, out_valid}, 64'd0);
        chk("mrst_in_ready",   {63'd0, in_ready}, 64'd0);
        chk("mrst_out_imm",    out_imm, 64'd0);
        chk("mrst_out_fmt",    {61'd0, out_fmt}, 64'd0);
        chk("mrst_out_target", out_target, 64'd0);
        chk("mrst_out_pc",     out_pc, 64'd0);
        chk("mrst_out_instr",  {32'd0, out_instr}, 64'd0);
        rst = 1'b0;
        #1;
        chk("mrst_release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("mrst_stays_empty", {63'd0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
